// File: rtl/ntt_stage_scheduler.sv
// In-place radix-2 NTT address scheduler: issues butterfly read pairs
// stage by stage and mirrors them onto a fixed-latency write-back path.
module ntt_stage_scheduler #(
  parameter int NUM_STAGES = 4,
  parameter int BF_LATENCY = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          bf_ready,
  output logic                          busy,
  output logic                          rd_valid,
  output logic [NUM_STAGES-1:0]         rd_addr_top,
  output logic [NUM_STAGES-1:0]         rd_addr_bot,
  output logic [NUM_STAGES-2:0]         tw_addr,
  output logic [$clog2(NUM_STAGES)-1:0] stage,
  output logic                          wr_valid,
  output logic [NUM_STAGES-1:0]         wr_addr_top,
  output logic [NUM_STAGES-1:0]         wr_addr_bot,
  output logic                          next_pair,
  output logic                          done
);

  localparam int AW = NUM_STAGES;
  localparam int JW = NUM_STAGES - 1;
  localparam int SW = $clog2(NUM_STAGES);
  localparam int DW = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]    r_state;
  logic [SW-1:0] r_stage;
  logic [JW-1:0] r_j;
  logic [DW-1:0] r_dcnt;

  logic [AW-1:0] r_rd_top, r_rd_bot;
  logic [JW-1:0] r_tw;

  logic [BF_LATENCY-1:0]         r_dv, r_dlast;
  logic [BF_LATENCY-1:0][AW-1:0] r_dtop, r_dbot;

  logic          w_issue, w_slast, w_dlast;
  logic [AW-1:0] w_jx, w_half, w_mask, w_top, w_bot;
  logic [JW-1:0] w_tw;

  assign w_issue = (r_state == S_RUN) & bf_ready;
  assign w_slast = (r_stage == SW'(NUM_STAGES - 1));
  assign w_dlast = (r_dcnt == DW'(BF_LATENCY - 1));

  // half = 2^k: top keeps j's low k bits and shifts the rest up by one
  always_comb begin
    w_jx   = {1'b0, r_j};
    w_half = AW'(1) << (SW'(NUM_STAGES - 1) - r_stage);
    w_mask = w_half - AW'(1);
    w_top  = ((w_jx & ~w_mask) << 1) | (w_jx & w_mask);
    w_bot  = w_top | w_half;
    w_tw   = JW'((w_jx & w_mask) << r_stage);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_stage <= '0;
      r_j     <= '0;
      r_dcnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_stage <= '0;
            r_j     <= '0;
          end
        end
        S_RUN: begin
          if (bf_ready) begin
            r_j <= r_j + 1'b1;
            if (&r_j) begin
              r_state <= S_DRAIN;
              r_dcnt  <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (w_dlast) begin
            r_dcnt <= '0;
            if (w_slast) begin
              r_state <= S_FINISH;
            end else begin
              r_stage <= r_stage + 1'b1;
              r_state <= S_RUN;
            end
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_top <= '0;
      r_rd_bot <= '0;
      r_tw     <= '0;
    end else if (w_issue) begin
      r_rd_top <= w_top;
      r_rd_bot <= w_bot;
      r_tw     <= w_tw;
    end
  end

  assign rd_valid    = w_issue;
  assign rd_addr_top = w_issue ? w_top : r_rd_top;
  assign rd_addr_bot = w_issue ? w_bot : r_rd_bot;
  assign tw_addr     = w_issue ? w_tw : r_tw;

  // Free-running: held read addresses flow in, so idle writes repeat the last one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dv    <= '0;
      r_dlast <= '0;
      r_dtop  <= '0;
      r_dbot  <= '0;
    end else begin
      for (int i = BF_LATENCY - 1; i > 0; i--) begin
        r_dv[i]    <= r_dv[i-1];
        r_dlast[i] <= r_dlast[i-1];
        r_dtop[i]  <= r_dtop[i-1];
        r_dbot[i]  <= r_dbot[i-1];
      end
      r_dv[0]    <= w_issue;
      r_dlast[0] <= w_issue & w_slast;
      r_dtop[0]  <= rd_addr_top;
      r_dbot[0]  <= rd_addr_bot;
    end
  end

  assign wr_valid    = r_dv[BF_LATENCY-1];
  assign wr_addr_top = r_dtop[BF_LATENCY-1];
  assign wr_addr_bot = r_dbot[BF_LATENCY-1];
  assign next_pair   = r_dv[BF_LATENCY-1] & r_dlast[BF_LATENCY-1];

  assign stage = r_stage;
  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_FINISH);

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Randomized bench for ntt_stage_scheduler against a pair-count
// timeline model with arithmetic address mapping.
module tb_ntt_stage_scheduler;

  localparam int NS = 4;
  localparam int BL = 3;
  localparam int NP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       bf_ready = 1'b0;
  logic       busy, rd_valid, wr_valid, next_pair, done;
  logic [3:0] rd_addr_top, rd_addr_bot, wr_addr_top, wr_addr_bot;
  logic [2:0] tw_addr;
  logic [1:0] stage;

  ntt_stage_scheduler #(.NUM_STAGES(NS), .BF_LATENCY(BL)) dut (
    .clk(clk), .reset(reset), .start(start), .bf_ready(bf_ready),
    .busy(busy), .rd_valid(rd_valid),
    .rd_addr_top(rd_addr_top), .rd_addr_bot(rd_addr_bot),
    .tw_addr(tw_addr), .stage(stage),
    .wr_valid(wr_valid),
    .wr_addr_top(wr_addr_top), .wr_addr_bot(wr_addr_bot),
    .next_pair(next_pair), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_busy = 0, m_fin = 0, m_stage = 0, m_j = 0, m_drain = 0;
  int h_top = 0, h_bot = 0, h_tw = 0;
  int e_rdv, e_top, e_bot, e_tw, e_last;
  int pv[BL], pt[BL], pb[BL], pl[BL];
  int t_iss = 0, t_np = 0, t_run = 0, n_done = 0;
  bit all_rdy = 0;

  initial begin
    for (int i = 0; i < BL; i++) begin
      pv[i] = 0; pt[i] = 0; pb[i] = 0; pl[i] = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic check_cycle();
    int half;
    e_rdv = (m_busy != 0 && m_fin == 0 && m_drain == 0 && bf_ready) ? 1 : 0;
    if (e_rdv != 0) begin
      half  = 1 << (NS - 1 - m_stage);
      e_top = (m_j / half) * 2 * half + (m_j % half);
      e_bot = e_top + half;
      e_tw  = (m_j % half) << m_stage;
    end else begin
      e_top = h_top;
      e_bot = h_bot;
      e_tw  = h_tw;
    end
    e_last = (e_rdv != 0 && m_stage == NS - 1) ? 1 : 0;
    chk("busy", busy, m_busy);
    chk("done", done, m_fin);
    chk("stage", stage, m_stage);
    chk("rd_valid", rd_valid, e_rdv);
    chk("rd_top", rd_addr_top, e_top);
    chk("rd_bot", rd_addr_bot, e_bot);
    chk("tw_addr", tw_addr, e_tw);
    chk("wr_valid", wr_valid, pv[BL-1]);
    chk("wr_top", wr_addr_top, pt[BL-1]);
    chk("wr_bot", wr_addr_bot, pb[BL-1]);
    chk("next_pair", next_pair, (pv[BL-1] != 0 && pl[BL-1] != 0) ? 1 : 0);
    if (rd_valid) t_iss++;
    if (next_pair) t_np++;
    if (busy && !done) t_run++;
    if (m_fin != 0) begin
      chk("issues", t_iss, NS * NP);
      chk("next_pair_cnt", t_np, NP);
      if (all_rdy) chk("run_cycles", t_run, NS * (NP + BL));
      n_done++;
    end
  endtask

  task automatic step();
    if (reset) begin
      m_busy = 0; m_fin = 0; m_stage = 0; m_j = 0; m_drain = 0;
      h_top = 0; h_bot = 0; h_tw = 0;
      for (int i = 0; i < BL; i++) begin
        pv[i] = 0; pt[i] = 0; pb[i] = 0; pl[i] = 0;
      end
    end else begin
      for (int i = BL - 1; i > 0; i--) begin
        pv[i] = pv[i-1]; pt[i] = pt[i-1];
        pb[i] = pb[i-1]; pl[i] = pl[i-1];
      end
      pv[0] = e_rdv; pt[0] = e_top; pb[0] = e_bot; pl[0] = e_last;
      if (e_rdv != 0) begin
        h_top = e_top; h_bot = e_bot; h_tw = e_tw;
      end
      if (m_busy == 0) begin
        if (start) begin
          m_busy = 1; m_stage = 0; m_j = 0; m_drain = 0;
          t_iss = 0; t_np = 0; t_run = 0;
        end
      end else if (m_fin != 0) begin
        m_fin = 0; m_busy = 0;
      end else if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) begin
          if (m_stage == NS - 1) m_fin = 1;
          else m_stage++;
        end
      end else if (bf_ready) begin
        m_j++;
        if (m_j == NP) begin
          m_j = 0;
          m_drain = BL;
        end
      end
    end
  endtask

  task automatic tick(input logic st, input logic rdy, input logic rs);
    @(posedge clk);
    #1;
    start = st;
    bf_ready = rdy;
    reset = rs;
    @(negedge clk);
    check_cycle();
    step();
  endtask

  // mode 0: always ready, 1: toggle in stage 0, 2: random ready and starts
  task automatic run_xform(input int mode, input logic hold_start);
    int   d0;
    logic tg;
    logic r;
    logic s;
    d0 = n_done;
    tg = 1'b1;
    all_rdy = (mode == 0);
    tick(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 400 && n_done == d0; c++) begin
      r = 1'b1;
      s = hold_start;
      if (mode == 1 && m_busy != 0 && m_stage == 0 && m_drain == 0) begin
        r  = tg;
        tg = ~tg;
      end
      if (mode == 2) begin
        r = ($urandom_range(0, 3) != 0);
        s = s | ($urandom_range(0, 7) == 0);
      end
      tick(s, r, 1'b0);
    end
    chk("xform_done", n_done, d0 + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int d0;
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b1, 1'b0);

    run_xform(0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    run_xform(1, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      run_xform(2, 1'b0);
      repeat ($urandom_range(0, 3)) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    run_xform(0, 1'b1);
    run_xform(0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);

    d0 = n_done;
    all_rdy = 0;
    tick(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 200; c++) begin
      if (m_busy != 0 && m_stage == 2 && m_j == 5 && m_drain == 0) break;
      tick(1'b0, 1'b1, 1'b0);
    end
    chk("abort_point", m_stage * 16 + m_j, 2 * 16 + 5);
    tick(1'b0, 1'b1, 1'b1);
    repeat (8) tick(1'b0, 1'b1, 1'b0);
    chk("abort_no_done", n_done, d0);
    run_xform(0, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_stage_scheduler.md
NTT_STAGE_SCHEDULER -- requirements
Module: ntt_stage_scheduler

Interface
REQ-001 Parameter NUM_STAGES, default 4, log2 of transform size; N = 2^NUM_STAGES points, N/2 butterfly pairs per stage.
REQ-002 Parameter BF_LATENCY, default 3, butterfly pipeline depth in cycles (>=1), read issue to write-back.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request one full transform; sampled only in IDLE.
REQ-006 bf_ready  input  1  butterfly may accept an issue this cycle; low inserts bubble.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 rd_valid  output  1  rd_addr_top/rd_addr_bot/tw_addr valid this cycle.
REQ-009 rd_addr_top, rd_addr_bot  output  NUM_STAGES each  pair read addresses.
REQ-010 tw_addr  output  NUM_STAGES-1  twiddle ROM index.
REQ-011 stage  output  clog2(NUM_STAGES)  current stage index.
REQ-012 wr_valid  output  1  wr_addr_top/wr_addr_bot valid this cycle.
REQ-013 wr_addr_top, wr_addr_bot  output  NUM_STAGES each  write-back addresses.
REQ-014 next_pair  output  1  pair strobe to output reorder unit.
REQ-015 done  output  1  single-cycle completion pulse.

Function
REQ-016 FSM states IDLE, RUN, DRAIN, FINISH.
REQ-017 IDLE: start=1 -> RUN, stage=0, pair counter j=0; start=0 -> stay.
REQ-018 RUN: cycle with bf_ready=1 issues pair j (rd_valid=1), j increments; bf_ready=0 -> rd_valid=0, j/stage held.
REQ-019 Pair mapping, stage s, half = 2^(NUM_STAGES-1-s): top = (j >> (NUM_STAGES-1-s)) * 2*half + (j mod half); bot = top + half; tw_addr = (j mod half) << s.
REQ-020 Issue of j = N/2-1 -> DRAIN; j wraps to 0.
REQ-021 DRAIN: no issue; lasts exactly BF_LATENCY cycles regardless of bf_ready; then stage<NUM_STAGES-1 -> stage+1, RUN; else FINISH.
REQ-022 FINISH: done=1 for exactly one cycle, then IDLE.
REQ-023 Write path: rd_valid/top/bot pass through BF_LATENCY-stage free-running delay line; wr_valid/wr_addr_* equal rd_valid/rd_addr_* delayed BF_LATENCY cycles; delay line not stalled by bf_ready.
REQ-024 next_pair = wr_valid AND write belongs to stage NUM_STAGES-1; exactly N/2 pulses per transform.
REQ-025 Last write-back of each stage occurs in the final DRAIN cycle; no read of stage s+1 precedes it.
REQ-026 start while busy ignored; no queuing.
REQ-027 rd_addr_*/tw_addr hold last issued values when rd_valid=0; wr_addr_* likewise when wr_valid=0.
REQ-028 Counters wrap only as in REQ-020; no arithmetic overflow beyond widths in REQ-009..011.

Reset
REQ-029 reset=1 -> IDLE; busy, rd_valid, wr_valid, next_pair, done = 0; all address, stage, counter and delay-line registers = 0.
REQ-030 reset overrides all inputs, including mid-transform; abandoned pipeline contents never produce wr_valid after reset.

Verification (NUM_STAGES=4, BF_LATENCY=3)
REQ-031 start pulse, bf_ready=1 constant -> stage 0 pairs (0,8),(1,9)..(7,15), tw 0..7; stage 1 pairs (0,4),(1,5),(2,6),(3,7),(8,12)..(11,15), tw 0,2,4,6,0,2,4,6; stage 3 pairs (0,1),(2,3)..(14,15), tw 0; 32 issues, 44 busy cycles in RUN/DRAIN, then done 1 cycle.
REQ-032 Same run, check wr side -> each wr pair equals rd pair 3 cycles earlier; next_pair pulses exactly 8 times, all in stage 3 write-back.
REQ-033 bf_ready toggled 1,0,1,0 during stage 0 -> rd_valid follows bf_ready, pair order unchanged, DRAIN still 3 cycles, total issues 32.
REQ-034 start held high through whole transform and one cycle after done -> second transform begins only after return to IDLE; no extra issues mid-run.
REQ-035 reset asserted at stage 2, j=5 -> next cycle IDLE, all outputs 0, no wr_valid/next_pair afterwards; subsequent start gives REQ-031 sequence.
